// File: rtl/utx_feeder.sv
// utx_feeder: byte FIFO + load/done sequencer feeding the UART transmitter.
// Optional CR insertion before LF when UTX_FEEDER_CRLF_EN is defined.
//
// Ports:
//   clk, rstn          clock, async active-low reset
//   wr_en, wr_data     byte write strobe and data (one per cycle max)
//   full, empty, count FIFO occupancy status
//   overflow, clr_ovf  sticky dropped-write flag and its sync clear
//   busy               sequencer not idle
//   tx_load, tx_byte   registered load pulse and byte to the transmitter
//   tx_done            completion pulse from the transmitter

module utx_feeder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  input  logic                clr_ovf,
  output logic                busy,
  output logic                tx_load,
  output logic [7:0]          tx_byte,
  input  logic                tx_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } state_t;

  state_t     state;
  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  logic [7:0] mem [DEPTH];
  logic [7:0] head;
  logic       push;
  logic       pop;

  assign full  = (count == cnt_t'(DEPTH));
  assign empty = (count == '0);
  assign busy  = (state != IDLE);
  assign head  = mem[rd_ptr];

`ifdef UTX_FEEDER_CRLF_EN
  logic cr_sent;
  logic hold;

  // A CR pass leaves the LF at the head for the next pass.
  assign pop = (state == LOAD) && !hold;
`else
  assign pop = (state == LOAD);
`endif

  // A pop on the same edge frees the slot a full FIFO needs.
  assign push = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      if (push && !pop)
        count <= count + cnt_t'(1);
      else if (pop && !push)
        count <= count - cnt_t'(1);
      if (wr_en && !push)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      tx_load <= 1'b0;
      tx_byte <= 8'h00;
`ifdef UTX_FEEDER_CRLF_EN
      cr_sent <= 1'b0;
      hold    <= 1'b0;
`endif
    end else begin
      tx_load <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state   <= LOAD;
            tx_load <= 1'b1;
            tx_byte <= head;
`ifdef UTX_FEEDER_CRLF_EN
            hold <= 1'b0;
            if (head == 8'h0A && !cr_sent) begin
              tx_byte <= 8'h0D;
              cr_sent <= 1'b1;
              hold    <= 1'b1;
            end else if (head == 8'h0A) begin
              cr_sent <= 1'b0;
            end
`endif
          end
        end
        LOAD: state <= WAIT;
        WAIT: if (tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_utx_feeder.sv
// tb_utx_feeder: directed + randomized bench for utx_feeder.
// A transmitter model answers loads with tx_done; a queue model predicts bytes.

module tb_utx_feeder;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       tx_done = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
  logic       tx_load;
  logic [7:0] tx_byte;

  int passes = 0;
  int fails = 0;
  int total = 0;
  int cyc = 0;

  bit done_en = 1'b1;
  int done_dly = 10;
  bit in_flight = 1'b0;
  int cnt = 0;
  int done_cyc = -100;

  byte unsigned loads[$];
  byte unsigned exp_q[$];

  utx_feeder #(.DEPTH_LOG2(4)) dut (
    .clk(clk),
    .rstn(rstn),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .clr_ovf(clr_ovf),
    .busy(busy),
    .tx_load(tx_load),
    .tx_byte(tx_byte),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] want);
    total++;
    assert (obs === want) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Expected transmit stream: every accepted byte, LF preceded by CR when
  // the CRLF build is selected.
  function automatic void push_exp(byte unsigned b);
`ifdef UTX_FEEDER_CRLF_EN
    if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(b);
  endfunction

  // Transmitter model: one frame in flight, done after done_dly cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        in_flight = 1'b0;
        tx_done = 1'b0;
        done_cyc = -100;
      end else begin
        if (tx_done) begin
          tx_done = 1'b0;
        end else if (in_flight && done_en) begin
          cnt--;
          if (cnt <= 0) begin
            tx_done = 1'b1;
            in_flight = 1'b0;
            done_cyc = cyc;
          end
        end
        if (tx_load) begin
          check("load_overlap", 32'(in_flight), 0);
          check("load_gap", 32'((cyc - done_cyc) >= 2), 1);
          loads.push_back(tx_byte);
          in_flight = 1'b1;
          cnt = done_dly;
        end
      end
    end
  end

  task automatic do_reset();
    wr_en = 1'b0;
    clr_ovf = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    loads.delete();
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic wait_drain(string tag, int bound);
    int n = 0;
    while (!(loads.size() >= exp_q.size() && !busy && empty && !in_flight)
           && n < bound) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_timeout", tag), 32'(n < bound), 1);
  endtask

  task automatic cmp_loads(string tag);
    check($sformatf("%s_nloads", tag), loads.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < loads.size())
        check($sformatf("%s_byte%0d", tag, i), loads[i], exp_q[i]);
    end
  endtask

  initial begin
    int n;
    int i;
    byte unsigned b;

    // Reset held with a write strobe active.
    rstn = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'hA5;
    repeat (4) begin
      @(negedge clk);
      check("rst_tx_load", tx_load, 0);
    end
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    wr_en = 1'b0;
    rstn = 1'b1;
    @(negedge clk);

    // Single byte and load latency.
    done_en = 1'b1;
    done_dly = 10;
    wr_en = 1'b1;
    wr_data = 8'h55;
    push_exp(8'h55);
    @(negedge clk);
    wr_en = 1'b0;
    check("sb_empty", empty, 0);
    check("sb_load_early", tx_load, 0);
    @(negedge clk);
    check("sb_load", tx_load, 1);
    check("sb_byte", tx_byte, 8'h55);
    @(negedge clk);
    check("sb_pulse", tx_load, 0);
    check("sb_busy", busy, 1);
    check("sb_count", count, 0);
    check("sb_empty2", empty, 1);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!tx_done && n < 50);
    check("sb_done_timeout", 32'(n < 50), 1);
    @(negedge clk);
    check("sb_busy_fall", busy, 0);
    check("sb_hold_byte", tx_byte, 8'h55);
    cmp_loads("sb");

    // Ordering and wrap, then random bytes, paced against full.
    do_reset();
    i = 0;
    n = 0;
    while (i < 100 && n < 5000) begin
      done_dly = $urandom_range(1, 12);
      if (!full && $urandom_range(0, 3) != 0) begin
        b = (i < 40) ? 8'(i) : 8'($urandom);
        wr_en = 1'b1;
        wr_data = b;
        push_exp(b);
        i++;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    wr_en = 1'b0;
    check("ord_write_timeout", 32'(n < 5000), 1);
    wait_drain("ord", 5000);
    cmp_loads("ord");
    check("ord_overflow", overflow, 0);
    check("ord_count", count, 0);

    // Overflow with tx_done withheld.
    do_reset();
    done_en = 1'b0;
    done_dly = 10;
    for (int k = 0; k < 18; k++) begin
      do b = 8'($urandom); while (b == 8'h0A);
      wr_en = 1'b1;
      wr_data = b;
      if (k < 17) push_exp(b);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("ovf_count", count, 16);
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_busy", busy, 1);
    check("ovf_nloads", loads.size(), 1);
    wr_en = 1'b1;
    wr_data = 8'h99;
    clr_ovf = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("ovf_count2", count, 16);
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_clear", overflow, 0);

    // Write on the LOAD cycle while full.
    done_en = 1'b1;
    n = 0;
    while (!tx_load && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sim_load_timeout", 32'(n < 50), 1);
    check("sim_count_pre", count, 16);
    wr_en = 1'b1;
    wr_data = 8'h3C;
    push_exp(8'h3C);
    @(negedge clk);
    wr_en = 1'b0;
    check("sim_count", count, 16);
    check("sim_full", full, 1);
    check("sim_overflow", overflow, 0);
    done_dly = 4;
    wait_drain("sim", 3000);
    cmp_loads("sim");

    // LF handling.
    do_reset();
    done_dly = 3;
    foreach (b_list[k]) begin
      wr_en = 1'b1;
      wr_data = b_list[k];
      push_exp(b_list[k]);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_drain("crlf", 500);
    cmp_loads("crlf");

    // Reset while a character is in flight and bytes are queued.
    do_reset();
    done_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h61 + k);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_pre", busy, 1);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_count", count, 0);
    check("mid_empty", empty, 1);
    check("mid_tx_byte", tx_byte, 8'h00);
    rstn = 1'b1;
    loads.delete();
    done_en = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_no_load", loads.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  byte unsigned b_list[4] = '{8'h41, 8'h0A, 8'h0A, 8'h42};

endmodule

// File: doc/utx_feeder.md
# utx_feeder

Byte FIFO and sequencer that sits directly upstream of the UART transmitter in the L.O.S.T. logger. It accepts bytes from the event formatter at any rate up to one per clock and buffers them. It hands bytes one at a time to the transmitter using that block's single-cycle `load` / `done` handshake, and never issues a load while a character is in flight.

## Interface
Parameters:
- `DEPTH_LOG2`, 4, log2 of FIFO depth (depth = 16 entries).

Ports (reset rstn, asynchronous, active-low; clock clk):
- `clk`  in  1  system clock, shared with the transmitter.
- `rstn`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  write strobe; one byte per cycle.
- `wr_data`  in  8  byte to enqueue.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  DEPTH_LOG2+1  current occupancy.
- `overflow`  out  1  sticky; set when a write is dropped.
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `busy`  out  1  sequencer is not in IDLE.
- `tx_load`  out  1  one-cycle load pulse to the transmitter.
- `tx_byte`  out  8  byte presented to the transmitter; registered.
- `tx_done`  in  1  one-cycle completion pulse from the transmitter, asserted after the stop bit.

## Operation
- Storage is a circular buffer with DEPTH_LOG2-bit read and write pointers that wrap modulo DEPTH, plus a `count` register. `full` and `empty` are decoded from `count`.
- Write path:
  - `wr_en` with `full`=0 stores `wr_data` at the write pointer and increments the pointer.
  - `wr_en` with `full`=1 and no pop in the same cycle drops the byte and sets `overflow`.
  - `wr_en` with `full`=1 and a pop in the same cycle is accepted. `count` is unchanged.
- `clr_ovf` clears `overflow`. If `clr_ovf` and a dropped write occur in the same cycle, set wins.
- Sequencer has three states:
  - IDLE: if `empty`=0, register the head byte into `tx_byte` and go to LOAD. Otherwise stay.
  - LOAD: assert `tx_load` for exactly this cycle, pop the FIFO (read pointer +1, count −1), go to WAIT.
  - WAIT: hold `tx_byte`. On `tx_done`=1, go to IDLE. `tx_done` seen in IDLE or LOAD is ignored.
- `busy` = (state ≠ IDLE).
- `tx_byte` is stable from the IDLE→LOAD edge until the next IDLE→LOAD edge.
- Reset values: `full`=0, `empty`=1, `count`=0, `overflow`=0, `busy`=0, `tx_load`=0, `tx_byte`=0x00. Pointers are 0 and the state is IDLE.
- Reset mid-operation discards all FIFO contents and any character in flight. The transmitter is reset by the same `rstn`.

## Timing
- A write at edge N makes `empty`=0 after edge N. `tx_byte` is valid after edge N+1. `tx_load` is high during cycle N+2 (the cycle after edge N+1).
- The pop and the `count` decrement take effect at the edge that ends the LOAD cycle.
- `tx_done` sampled high at edge M moves the state to IDLE. The next `tx_load` is high in the cycle after edge M+1. This gives a minimum 2-cycle gap between `tx_done` and the next load.
- `tx_load` is never asserted while the state is WAIT. This guarantees no load ever overlaps a transmitter frame.
- `count` saturates at DEPTH under the full-with-pop rule. It never wraps.

## Configuration
- Macro: `UTX_FEEDER_CRLF_EN`.
- Defined:
  - In IDLE, if the head byte is 0x0A and internal flag `cr_sent`=0, load 0x0D instead, set `cr_sent`, and skip the pop in LOAD.
  - The following pass sends 0x0A, pops, and clears `cr_sent`.
  - `cr_sent` resets to 0.
- Undefined: bytes are sent verbatim. The `cr_sent` flag and its logic are absent.

## Test plan
- Reset: hold `rstn`=0 with `wr_en`=1 → all outputs at their reset values and no `tx_load` pulse.
- Single byte: write 0x55, model `tx_done` 10 cycles after the load → one `tx_load` with `tx_byte`=0x55 exactly 2 cycles after the write edge; `busy` falls the cycle after `tx_done`; `empty`=1.
- Ordering and wrap: write 40 bytes 0x00..0x27, pacing writes against `full` → loads occur in order 0x00..0x27, pointers wrap twice, no `overflow`.
- Overflow: with `tx_done` withheld, write 18 bytes → `count`=16 after the first load pops once and refills to full; `overflow`=1; `clr_ovf` → `overflow`=0.
- Simultaneous write and pop when full: write on the LOAD cycle → byte accepted, `count` stays 16, `overflow` stays 0.
- CRLF (macro defined): write 0x41, 0x0A → loads 0x41, 0x0D, 0x0A in that order. With the macro undefined, the same writes → loads 0x41, 0x0A.
